// File: rtl/dehaze_pkg.sv
// Shared types and constants for the dehaze pipeline controllers.
// Holds the atmospheric-light FSM encoding, default geometry and per-channel A helpers.
package dehaze_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LATCH  = 2'd2
  } atm_state_e;

  localparam int         H_ACT_DEF      = 1280;
  localparam int         V_ACT_DEF      = 720;
  localparam logic [7:0] A_RESET        = 8'd255;
  localparam int         A_SMOOTH_SHIFT = 2;

  function automatic logic [7:0] floor_chan(input logic [7:0] v, input logic [7:0] lo);
    if (v < lo) begin
      floor_chan = lo;
    end else begin
      floor_chan = v;
    end
  endfunction

  // (3*a_old + a_frame) >> shift with a 10-bit intermediate, truncating
  function automatic logic [7:0] smooth_chan(input logic [7:0] a_old, input logic [7:0] a_frame);
    logic [9:0] acc;
    acc = {2'b00, a_old} + {1'b0, a_old, 1'b0} + {2'b00, a_frame};
    smooth_chan = 8'(acc >> A_SMOOTH_SHIFT);
  endfunction

endpackage

// File: rtl/dehaze_atm_ctrl_if.sv
// Pixel-stream input and atmospheric-light result bundle for dehaze_atm_ctrl.
// master = upstream pixel source / result consumer, slave = the controller.
interface dehaze_atm_ctrl_if
  import dehaze_pkg::*;
#(
  parameter int H_ACT = H_ACT_DEF,
  parameter int V_ACT = V_ACT_DEF
);
  localparam int XW = $clog2(H_ACT);
  localparam int YW = $clog2(V_ACT);

  logic [7:0]    i_dark;
  logic [23:0]   i_rgb;
  logic          i_hsync;
  logic          i_vsync;
  logic          i_de;
  logic [7:0]    o_atm_r;
  logic [7:0]    o_atm_g;
  logic [7:0]    o_atm_b;
  logic          o_atm_valid;
  logic          o_frame_err;
  logic [XW-1:0] o_max_x;
  logic [YW-1:0] o_max_y;

  modport master (
    output i_dark, i_rgb, i_hsync, i_vsync, i_de,
    input  o_atm_r, o_atm_g, o_atm_b, o_atm_valid, o_frame_err, o_max_x, o_max_y
  );

  modport slave (
    input  i_dark, i_rgb, i_hsync, i_vsync, i_de,
    output o_atm_r, o_atm_g, o_atm_b, o_atm_valid, o_frame_err, o_max_x, o_max_y
  );
endinterface

// File: rtl/dark_max_tracker.sv
// Tracks the brightest dark-channel pixel of a frame with its RGB and coordinates.
// The first strobed pixel after a clear is always taken, so a flat frame selects (0,0).
module dark_max_tracker #(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic          pixelclk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          stb,
  input  logic [7:0]    dark,
  input  logic [23:0]   rgb,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [23:0]   max_rgb,
  output logic [XW-1:0] max_x,
  output logic [YW-1:0] max_y
);

  logic [7:0]    max_dark_r;
  logic [23:0]   max_rgb_r;
  logic [XW-1:0] max_x_r;
  logic [YW-1:0] max_y_r;
  logic          first_r;

  // Strict greater-than keeps the first of equal maxima in raster order
  always_ff @(posedge pixelclk) begin
    if (!reset_n || clr) begin
      max_dark_r <= 8'd0;
      max_rgb_r  <= 24'd0;
      max_x_r    <= '0;
      max_y_r    <= '0;
      first_r    <= 1'b1;
    end else if (stb && (first_r || (dark > max_dark_r))) begin
      max_dark_r <= dark;
      max_rgb_r  <= rgb;
      max_x_r    <= x;
      max_y_r    <= y;
      first_r    <= 1'b0;
    end else begin
      max_dark_r <= max_dark_r;
      max_rgb_r  <= max_rgb_r;
      max_x_r    <= max_x_r;
      max_y_r    <= max_y_r;
      first_r    <= first_r;
    end
  end

  assign max_rgb = max_rgb_r;
  assign max_x   = max_x_r;
  assign max_y   = max_y_r;

endmodule

// File: rtl/dehaze_atm_ctrl.sv
// Frame-level atmospheric-light controller: latches A from the brightest dark pixel per frame.
// Optional temporal smoothing of A is enabled by defining DEHAZE_A_SMOOTH_EN.
module dehaze_atm_ctrl
  import dehaze_pkg::*;
#(
  parameter int         H_ACT = H_ACT_DEF,
  parameter int         V_ACT = V_ACT_DEF,
  parameter logic [7:0] A_MIN = 8'd100
) (
  input logic         pixelclk,
  input logic         reset_n,
  dehaze_atm_ctrl_if.slave bus
);

  localparam int XW  = $clog2(H_ACT);
  localparam int YW  = $clog2(V_ACT);
  // Counters must be able to hold H_ACT/V_ACT themselves for the geometry check
  localparam int CXW = $clog2(H_ACT + 1);
  localparam int CYW = $clog2(V_ACT + 1);
  localparam logic [CXW-1:0] X_END = CXW'(H_ACT);
  localparam logic [CYW-1:0] Y_END = CYW'(V_ACT);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACTIVE = ST_ACTIVE;
  localparam logic [1:0] S_LATCH  = ST_LATCH;

  logic [1:0]     state_r;
  logic [1:0]     state_nxt_s;
  logic           vsync_d_r;
  logic           de_d_r;
  logic [CXW-1:0] x_r;
  logic [CYW-1:0] y_r;
  logic           err_r;
  logic           vs_rise_s;
  logic           de_fall_s;
  logic           enter_act_s;
  logic           stb_s;
  logic           frame_bad_s;
  logic [23:0]    cap_rgb_s;
  logic [XW-1:0]  cap_x_s;
  logic [YW-1:0]  cap_y_s;
  logic [7:0]     a_new_r_s;
  logic [7:0]     a_new_g_s;
  logic [7:0]     a_new_b_s;
  logic [7:0]     atm_r_r;
  logic [7:0]     atm_g_r;
  logic [7:0]     atm_b_r;
  logic           atm_valid_r;
  logic           frame_err_r;
  logic [XW-1:0]  max_x_r;
  logic [YW-1:0]  max_y_r;

  // Sync edge detection and next-state selection
  always_comb begin
    vs_rise_s   = bus.i_vsync & ~vsync_d_r;
    de_fall_s   = de_d_r & ~bus.i_de;
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (vs_rise_s) state_nxt_s = S_ACTIVE;
        else           state_nxt_s = S_IDLE;
      end
      S_ACTIVE: begin
        if (vs_rise_s) state_nxt_s = S_LATCH;
        else           state_nxt_s = S_ACTIVE;
      end
      S_LATCH: state_nxt_s = S_ACTIVE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  assign enter_act_s = (state_nxt_s == S_ACTIVE) && (state_r != S_ACTIVE);
  assign stb_s       = (state_r == S_ACTIVE) && bus.i_de;
  assign frame_bad_s = err_r || (y_r != Y_END);

  // FSM state, sync delays, saturating pixel/line counters and sticky geometry error
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      state_r   <= S_IDLE;
      vsync_d_r <= 1'b1;   // a vsync already high at reset release is not a fresh edge
      de_d_r    <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      vsync_d_r <= bus.i_vsync;
      de_d_r    <= bus.i_de;
      if (enter_act_s) begin
        x_r   <= '0;
        y_r   <= '0;
        err_r <= 1'b0;
      end else if (state_r == S_ACTIVE) begin
        if (de_fall_s) begin
          if (x_r != X_END) err_r <= 1'b1;
          if (y_r != {CYW{1'b1}}) y_r <= y_r + CYW'(1);
          x_r <= '0;
        end else if (bus.i_de && (x_r != {CXW{1'b1}})) begin
          x_r <= x_r + CXW'(1);
        end
      end
    end
  end

  dark_max_tracker #(
    .XW (XW),
    .YW (YW)
  ) u_tracker (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .clr      (enter_act_s),
    .stb      (stb_s),
    .dark     (bus.i_dark),
    .rgb      (bus.i_rgb),
    .x        (x_r[XW-1:0]),
    .y        (y_r[YW-1:0]),
    .max_rgb  (cap_rgb_s),
    .max_x    (cap_x_s),
    .max_y    (cap_y_s)
  );

`ifdef DEHAZE_A_SMOOTH_EN
  logic [7:0] filt_r_r;
  logic [7:0] filt_g_r;
  logic [7:0] filt_b_r;
  logic       filt_seeded_r;

  // IIR blend of the captured colour; the first good frame seeds the filter directly
  always_comb begin
    if (filt_seeded_r) begin
      a_new_r_s = smooth_chan(filt_r_r, cap_rgb_s[23:16]);
      a_new_g_s = smooth_chan(filt_g_r, cap_rgb_s[15:8]);
      a_new_b_s = smooth_chan(filt_b_r, cap_rgb_s[7:0]);
    end else begin
      a_new_r_s = cap_rgb_s[23:16];
      a_new_g_s = cap_rgb_s[15:8];
      a_new_b_s = cap_rgb_s[7:0];
    end
  end

  // Filter state advances only on frames that pass the geometry check
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      filt_r_r      <= A_RESET;
      filt_g_r      <= A_RESET;
      filt_b_r      <= A_RESET;
      filt_seeded_r <= 1'b0;
    end else if ((state_r == S_LATCH) && !frame_bad_s) begin
      filt_r_r      <= a_new_r_s;
      filt_g_r      <= a_new_g_s;
      filt_b_r      <= a_new_b_s;
      filt_seeded_r <= 1'b1;
    end else begin
      filt_r_r      <= filt_r_r;
      filt_g_r      <= filt_g_r;
      filt_b_r      <= filt_b_r;
      filt_seeded_r <= filt_seeded_r;
    end
  end
`else
  // Unfiltered: A follows the captured colour of each good frame
  always_comb begin
    a_new_r_s = cap_rgb_s[23:16];
    a_new_g_s = cap_rgb_s[15:8];
    a_new_b_s = cap_rgb_s[7:0];
  end
`endif

  // Result registers: A, coordinates and the mutually exclusive pulses
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      atm_r_r     <= A_RESET;
      atm_g_r     <= A_RESET;
      atm_b_r     <= A_RESET;
      atm_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      max_x_r     <= '0;
      max_y_r     <= '0;
    end else begin
      atm_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
      if (state_r == S_LATCH) begin
        if (frame_bad_s) begin
          frame_err_r <= 1'b1;
        end else begin
          atm_valid_r <= 1'b1;
          atm_r_r     <= floor_chan(a_new_r_s, A_MIN);
          atm_g_r     <= floor_chan(a_new_g_s, A_MIN);
          atm_b_r     <= floor_chan(a_new_b_s, A_MIN);
          max_x_r     <= cap_x_s;
          max_y_r     <= cap_y_s;
        end
      end
    end
  end

  assign bus.o_atm_r     = atm_r_r;
  assign bus.o_atm_g     = atm_g_r;
  assign bus.o_atm_b     = atm_b_r;
  assign bus.o_atm_valid = atm_valid_r;
  assign bus.o_frame_err = frame_err_r;
  assign bus.o_max_x     = max_x_r;
  assign bus.o_max_y     = max_y_r;

endmodule
